// File: rtl/m3ds_sram_port_arbiter.sv
// Two-requester arbiter for one AHB2SRAM bank port: round-robin on ties, optional
// locked bursts capped at MAX_BURST while the other side waits, 1-cycle read return.
module m3ds_sram_port_arbiter #(
    parameter int AW        = 13,
    parameter int DW        = 32,
    parameter int MAX_BURST = 8
) (
    input  logic              SRAMHCLK,
    input  logic              SRAMHRESET,
    input  logic              M0REQ,
    input  logic              M0LOCK,
    input  logic [AW-1:0]     M0ADDR,
    input  logic [DW/8-1:0]   M0WREN,
    input  logic [DW-1:0]     M0WDATA,
    output logic              M0GNT,
    output logic              M0RVALID,
    output logic [DW-1:0]     M0RDATA,
    input  logic              M1REQ,
    input  logic              M1LOCK,
    input  logic [AW-1:0]     M1ADDR,
    input  logic [DW/8-1:0]   M1WREN,
    input  logic [DW-1:0]     M1WDATA,
    output logic              M1GNT,
    output logic              M1RVALID,
    output logic [DW-1:0]     M1RDATA,
    output logic [AW-1:0]     SRAMADDR,
    output logic [DW/8-1:0]   SRAMWREN,
    output logic [DW-1:0]     SRAMWDATA,
    output logic              SRAMCS,
    input  logic [DW-1:0]     SRAMRDATA
);

    localparam int CW = $clog2(MAX_BURST + 1);
    localparam logic [CW-1:0] BURST_LIMIT = CW'(MAX_BURST);

    logic          r_rr_ptr;
    logic          r_lock_own;
    logic          r_lock_id;
    logic [CW-1:0] r_burst_cnt;
    logic [1:0]    r_rd_pend;

    logic          w_own_req;
    logic          w_oth_req;
    logic          w_hold;
    logic          w_break;
    logic          w_gnt0;
    logic          w_gnt1;
    logic          w_any;
    logic          w_win_lock;
    logic          w_rd0;
    logic          w_rd1;

    // Grant selection: lock hold first, then single request, then round-robin tie.
    always_comb begin
        w_own_req = r_lock_id ? M1REQ : M0REQ;
        w_oth_req = r_lock_id ? M0REQ : M1REQ;
        w_hold    = 1'b0;
        w_break   = 1'b0;
        w_gnt0    = 1'b0;
        w_gnt1    = 1'b0;
        if (r_lock_own && w_own_req) begin
            if (w_oth_req && (r_burst_cnt == BURST_LIMIT)) begin
                w_break = 1'b1;
                w_gnt0  = r_lock_id;
                w_gnt1  = ~r_lock_id;
            end else begin
                w_hold = 1'b1;
                w_gnt0 = ~r_lock_id;
                w_gnt1 = r_lock_id;
            end
        end else if (M0REQ && M1REQ) begin
            w_gnt0 = ~r_rr_ptr;
            w_gnt1 = r_rr_ptr;
        end else begin
            w_gnt0 = M0REQ;
            w_gnt1 = M1REQ;
        end
        if (SRAMHRESET) begin
            w_hold  = 1'b0;
            w_break = 1'b0;
            w_gnt0  = 1'b0;
            w_gnt1  = 1'b0;
        end
    end

    assign w_any      = w_gnt0 | w_gnt1;
    assign w_win_lock = (w_gnt0 & M0LOCK) | (w_gnt1 & M1LOCK);
    assign w_rd0      = w_gnt0 && (M0WREN == '0);
    assign w_rd1      = w_gnt1 && (M1WREN == '0);

    assign M0GNT = w_gnt0;
    assign M1GNT = w_gnt1;

    // Idle cycles drive zeros so the SRAM port never sees a stale address.
    always_comb begin
        SRAMCS    = w_any;
        SRAMADDR  = '0;
        SRAMWREN  = '0;
        SRAMWDATA = '0;
        if (w_gnt0) begin
            SRAMADDR  = M0ADDR;
            SRAMWREN  = M0WREN;
            SRAMWDATA = M0WDATA;
        end else if (w_gnt1) begin
            SRAMADDR  = M1ADDR;
            SRAMWREN  = M1WREN;
            SRAMWDATA = M1WDATA;
        end
    end

    always_ff @(posedge SRAMHCLK) begin
        if (SRAMHRESET) begin
            r_rr_ptr    <= 1'b0;
            r_lock_own  <= 1'b0;
            r_lock_id   <= 1'b0;
            r_burst_cnt <= '0;
            r_rd_pend   <= 2'b00;
        end else begin
            r_rd_pend <= {w_rd1, w_rd0};
            if (w_any) begin
                r_rr_ptr <= w_gnt0;
                if (w_win_lock && !w_break) begin
                    r_lock_own <= 1'b1;
                    r_lock_id  <= w_gnt1;
                end else begin
                    r_lock_own <= 1'b0;
                end
                // Only a continued hold against a waiting requester counts toward the cap.
                if (w_hold && w_oth_req && w_win_lock) begin
                    if (r_burst_cnt != BURST_LIMIT) begin
                        r_burst_cnt <= r_burst_cnt + CW'(1);
                    end
                end else begin
                    r_burst_cnt <= '0;
                end
            end else begin
                r_lock_own  <= 1'b0;
                r_burst_cnt <= '0;
            end
        end
    end

    assign M0RVALID = r_rd_pend[0] & ~SRAMHRESET;
    assign M1RVALID = r_rd_pend[1] & ~SRAMHRESET;
    assign M0RDATA  = M0RVALID ? SRAMRDATA : '0;
    assign M1RDATA  = M1RVALID ? SRAMRDATA : '0;

endmodule

// File: tb/tb_m3ds_sram_port_arbiter.sv
// Directed bench for m3ds_sram_port_arbiter with a small behavioural SRAM behind the port.
module tb_m3ds_sram_port_arbiter;

  logic        clk;
  logic        rst;
  logic        m0_req, m0_lock, m1_req, m1_lock;
  logic [12:0] m0_addr, m1_addr;
  logic [3:0]  m0_wren, m1_wren;
  logic [31:0] m0_wdata, m1_wdata;
  logic        m0_gnt, m1_gnt, m0_rvalid, m1_rvalid;
  logic [31:0] m0_rdata, m1_rdata;
  logic [12:0] sram_addr;
  logic [3:0]  sram_wren;
  logic [31:0] sram_wdata;
  logic        sram_cs;
  logic [31:0] sram_rdata;

  logic [31:0] mem [0:8191];
  int          n_chk;
  int          n_err;

  m3ds_sram_port_arbiter dut (
    .SRAMHCLK   (clk),
    .SRAMHRESET (rst),
    .M0REQ      (m0_req),
    .M0LOCK     (m0_lock),
    .M0ADDR     (m0_addr),
    .M0WREN     (m0_wren),
    .M0WDATA    (m0_wdata),
    .M0GNT      (m0_gnt),
    .M0RVALID   (m0_rvalid),
    .M0RDATA    (m0_rdata),
    .M1REQ      (m1_req),
    .M1LOCK     (m1_lock),
    .M1ADDR     (m1_addr),
    .M1WREN     (m1_wren),
    .M1WDATA    (m1_wdata),
    .M1GNT      (m1_gnt),
    .M1RVALID   (m1_rvalid),
    .M1RDATA    (m1_rdata),
    .SRAMADDR   (sram_addr),
    .SRAMWREN   (sram_wren),
    .SRAMWDATA  (sram_wdata),
    .SRAMCS     (sram_cs),
    .SRAMRDATA  (sram_rdata)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // behavioural SRAM: one-cycle read latency, byte writes
  always @(posedge clk) begin
    if (sram_cs) begin
      if (sram_wren == 4'h0) begin
        sram_rdata <= mem[sram_addr];
      end else begin
        for (int b = 0; b < 4; b++) begin
          if (sram_wren[b]) mem[sram_addr][b*8 +: 8] <= sram_wdata[b*8 +: 8];
        end
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic clear_inputs;
    m0_req = 0; m0_lock = 0; m0_addr = '0; m0_wren = '0; m0_wdata = '0;
    m1_req = 0; m1_lock = 0; m1_addr = '0; m1_wren = '0; m1_wdata = '0;
  endtask

  task automatic cyc;
    @(negedge clk);
    rst = 1'b0;
  endtask

  // one reset cycle with live requests; outputs must all be quiet
  task automatic do_reset;
    @(negedge clk);
    rst = 1'b1;
    m0_req = 1; m0_addr = 13'h0aa; m0_wdata = 32'h1111_2222;
    m1_req = 1; m1_addr = 13'h155; m1_wdata = 32'h3333_4444;
    #1;
    chk("rst_gnt", {m0_gnt, m1_gnt}, 32'h0);
    chk("rst_cs", sram_cs, 32'h0);
    chk("rst_addr", sram_addr, 32'h0);
    chk("rst_wdata", sram_wdata, 32'h0);
    chk("rst_rvalid", {m0_rvalid, m1_rvalid}, 32'h0);
    chk("rst_rdata", m0_rdata | m1_rdata, 32'h0);
    clear_inputs();
  endtask

  initial begin
    n_chk = 0;
    n_err = 0;
    rst = 1'b1;
    sram_rdata = '0;
    clear_inputs();
    for (int i = 0; i < 8192; i++) mem[i] = 32'hA5A5_0000 | 32'(i);

    // single requester: write then read back
    do_reset();
    cyc(); m0_req = 1; m0_addr = 13'h0010; m0_wren = 4'hF; m0_wdata = 32'hDEADBEEF; #1;
    chk("wr_gnt", m0_gnt, 32'h1);
    chk("wr_cs", sram_cs, 32'h1);
    chk("wr_wren", sram_wren, 32'hF);
    chk("wr_wdata", sram_wdata, 32'hDEADBEEF);
    cyc(); m0_wren = 4'h0; m0_wdata = 32'h0; #1;
    chk("rd_gnt", m0_gnt, 32'h1);
    chk("rd_addr", sram_addr, 32'h0010);
    chk("wr_no_rvalid", m0_rvalid, 32'h0);
    cyc(); m0_req = 0; #1;
    chk("rd_rvalid", {m0_rvalid, m1_rvalid}, 32'h2);
    chk("rd_rdata", m0_rdata, 32'hDEADBEEF);
    chk("rd_other_rdata", m1_rdata, 32'h0);

    // tie round-robin from reset, alternating reads
    do_reset();
    cyc(); m0_req = 1; m0_addr = 13'h0100; m1_req = 1; m1_addr = 13'h0200; #1;
    chk("rr_c1", {m0_gnt, m1_gnt}, 32'h2);
    chk("rr_c1_addr", sram_addr, 32'h0100);
    cyc(); #1;
    chk("rr_c2", {m0_gnt, m1_gnt}, 32'h1);
    chk("rr_c2_addr", sram_addr, 32'h0200);
    chk("rr_c2_rvalid", {m0_rvalid, m1_rvalid}, 32'h2);
    chk("rr_c2_rdata", m0_rdata, 32'hA5A5_0100);
    cyc(); #1;
    chk("rr_c3", {m0_gnt, m1_gnt}, 32'h2);
    chk("rr_c3_rvalid", {m0_rvalid, m1_rvalid}, 32'h1);
    chk("rr_c3_rdata", m1_rdata, 32'hA5A5_0200);
    chk("rr_c3_m0_rdata", m0_rdata, 32'h0);
    cyc(); #1;
    chk("rr_c4", {m0_gnt, m1_gnt}, 32'h1);

    // locked burst: 9 grants to M1, forced break to M0, round-robin resumes
    do_reset();
    cyc(); m1_req = 1; m1_lock = 1; m1_addr = 13'h0300; #1;
    chk("burst_first", {m0_gnt, m1_gnt}, 32'h1);
    for (int k = 2; k <= 9; k++) begin
      cyc(); m0_req = 1; m0_addr = 13'h0400; #1;
      chk($sformatf("burst_hold%0d", k), {m0_gnt, m1_gnt}, 32'h1);
    end
    cyc(); #1;
    chk("burst_break", {m0_gnt, m1_gnt}, 32'h2);
    chk("burst_break_addr", sram_addr, 32'h0400);
    cyc(); m1_lock = 0; #1;
    chk("burst_rr1", {m0_gnt, m1_gnt}, 32'h1);
    cyc(); #1;
    chk("burst_rr2", {m0_gnt, m1_gnt}, 32'h2);
    cyc(); #1;
    chk("burst_rr3", {m0_gnt, m1_gnt}, 32'h1);

    // lock release: owner drops request, other side granted same cycle
    do_reset();
    cyc(); m0_req = 1; m0_lock = 1; m0_addr = 13'h0600; m1_req = 1; m1_addr = 13'h0700; #1;
    chk("rel_c1", {m0_gnt, m1_gnt}, 32'h2);
    cyc(); #1;
    chk("rel_c2", {m0_gnt, m1_gnt}, 32'h2);
    cyc(); #1;
    chk("rel_c3", {m0_gnt, m1_gnt}, 32'h2);
    cyc(); m0_req = 0; #1;
    chk("rel_switch", {m0_gnt, m1_gnt}, 32'h1);
    chk("rel_switch_addr", sram_addr, 32'h0700);
    cyc(); m0_req = 1; m0_lock = 0; #1;
    chk("rel_after", {m0_gnt, m1_gnt}, 32'h2);

    // reset right after a locked M1 read grant
    do_reset();
    cyc(); m1_req = 1; m1_lock = 1; m1_addr = 13'h0500; #1;
    chk("mid_m1_gnt", {m0_gnt, m1_gnt}, 32'h1);
    do_reset();
    cyc(); m0_req = 1; m0_wren = 4'hF; m0_addr = 13'h0800; m1_req = 1; m1_lock = 1; m1_addr = 13'h0500; #1;
    chk("mid_after_gnt", {m0_gnt, m1_gnt}, 32'h2);
    chk("mid_after_rvalid", {m0_rvalid, m1_rvalid}, 32'h0);

    // idle bus: inputs carry junk but nothing is requested
    cyc(); clear_inputs();
    m0_addr = 13'h1abc; m0_wren = 4'h3; m0_wdata = 32'hCAFE_F00D;
    m1_addr = 13'h0123; m1_wren = 4'hC; m1_wdata = 32'h1234_5678;
    for (int k = 0; k < 10; k++) begin
      #1;
      chk($sformatf("idle%0d_bus", k), {sram_cs, sram_wren, m0_gnt, m1_gnt}, 32'h0);
      chk($sformatf("idle%0d_addr", k), {19'h0, sram_addr} | sram_wdata, 32'h0);
      chk($sformatf("idle%0d_rvalid", k), {m0_rvalid, m1_rvalid}, 32'h0);
      cyc();
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
